// File: rtl/ext_pkg.sv
// Shared definitions for the RV32M extension-port sequencer: funct3 codes,
// FSM state encoding and the divide-by-zero quotient.
package ext_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_FIX   = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  function automatic logic a_is_signed(input logic [2:0] f);
    return !(f == F3_MULHU || f == F3_DIVU || f == F3_REMU);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == F3_MUL || f == F3_MULH || f == F3_DIV || f == F3_REM);
  endfunction

endpackage

// File: rtl/ext_signfix.sv
// Combinational sign handling: operand magnitudes/sign flags on the way in,
// negate and high/low or quotient/remainder selection on the way out.
module ext_signfix
  import ext_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic        sign_a,
  output logic        sign_b,
  input  logic [2:0]  res_func3,
  input  logic        res_sign_a,
  input  logic        res_sign_b,
  input  logic        res_dbz,
  input  logic [31:0] res_a,
  input  logic [63:0] prod,
  input  logic [31:0] quo,
  input  logic [31:0] rem,
  output logic [31:0] result
);

  logic [63:0] prod_fix;
  logic [31:0] mul_res;
  logic [31:0] div_res;

  assign sign_a = a_is_signed(func3) && a[31];
  assign sign_b = b_is_signed(func3) && b[31];
  assign mag_a  = sign_a ? (~a + 32'd1) : a;
  assign mag_b  = sign_b ? (~b + 32'd1) : b;

  always_comb begin
    prod_fix = (res_sign_a ^ res_sign_b) ? (~prod + 64'd1) : prod;
    mul_res  = (res_func3 == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];
    div_res  = 32'd0;
    // func3[1] separates remainder ops from quotient ops
    if (res_dbz) begin
      div_res = res_func3[1] ? res_a : DBZ_QUOTIENT;
    end else if (res_func3[1]) begin
      div_res = res_sign_a ? (~rem + 32'd1) : rem;
    end else begin
      div_res = (res_sign_a ^ res_sign_b) ? (~quo + 32'd1) : quo;
    end
    result = res_func3[2] ? div_res : mul_res;
  end

endmodule

// File: rtl/ext_dispatch.sv
// Extension-port sequencer routing RV32M ops to a shared multiplier/divider.
// Optional WAIT-state watchdog enabled by defining EXT_TIMEOUT_EN.
module ext_dispatch
  import ext_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        extStart,
  input  logic [2:0]  extFunc3,
  input  logic [31:0] extA,
  input  logic [31:0] extB,
  output logic [31:0] extR,
  output logic        extDone,
  output logic        extBusy,
  output logic        extErr,
  output logic        mulStart,
  output logic [31:0] mulA,
  output logic [31:0] mulB,
  input  logic [63:0] mulP,
  input  logic        mulDone,
  output logic        divStart,
  output logic [31:0] divA,
  output logic [31:0] divB,
  input  logic [31:0] divQ,
  input  logic [31:0] divRem,
  input  logic        divDone
);

  state_t      state_reg;
  logic [2:0]  func_reg;
  logic [31:0] a_reg;
  logic [31:0] mag_a_reg;
  logic [31:0] mag_b_reg;
  logic        sign_a_reg;
  logic        sign_b_reg;
  logic        dbz_reg;
  logic [63:0] prod_reg;
  logic [31:0] quo_reg;
  logic [31:0] rem_reg;
  logic [31:0] r_reg;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] result;
  logic        unit_done;

  ext_signfix u_signfix (
    .func3      (extFunc3),
    .a          (extA),
    .b          (extB),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .sign_a     (sign_a),
    .sign_b     (sign_b),
    .res_func3  (func_reg),
    .res_sign_a (sign_a_reg),
    .res_sign_b (sign_b_reg),
    .res_dbz    (dbz_reg),
    .res_a      (a_reg),
    .prod       (prod_reg),
    .quo        (quo_reg),
    .rem        (rem_reg),
    .result     (result)
  );

  assign unit_done = func_reg[2] ? divDone : mulDone;

`ifdef EXT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             err_reg;

  assign cnt_next = cnt_reg + CNT_W'(1);
  assign extErr   = err_reg;
`else
  assign extErr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      func_reg   <= 3'd0;
      a_reg      <= 32'd0;
      mag_a_reg  <= 32'd0;
      mag_b_reg  <= 32'd0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      dbz_reg    <= 1'b0;
      prod_reg   <= 64'd0;
      quo_reg    <= 32'd0;
      rem_reg    <= 32'd0;
      r_reg      <= 32'd0;
`ifdef EXT_TIMEOUT_EN
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (extStart) begin
            func_reg   <= extFunc3;
            a_reg      <= extA;
            mag_a_reg  <= mag_a;
            mag_b_reg  <= mag_b;
            sign_a_reg <= sign_a;
            sign_b_reg <= sign_b;
            dbz_reg    <= extFunc3[2] && (extB == 32'd0);
`ifdef EXT_TIMEOUT_EN
            err_reg    <= 1'b0;
`endif
            // divide by zero never engages the divider
            state_reg  <= (extFunc3[2] && (extB == 32'd0)) ? ST_FIX : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef EXT_TIMEOUT_EN
          cnt_reg   <= '0;
`endif
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (unit_done) begin
            prod_reg  <= mulP;
            quo_reg   <= divQ;
            rem_reg   <= divRem;
            state_reg <= ST_FIX;
          end
`ifdef EXT_TIMEOUT_EN
          else if (cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
            r_reg     <= 32'd0;
            err_reg   <= 1'b1;
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_next;
          end
`endif
        end
        ST_FIX: begin
          r_reg     <= result;
          state_reg <= ST_RESP;
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign extR     = r_reg;
  assign extDone  = (state_reg == ST_RESP);
  assign extBusy  = (state_reg != ST_IDLE);
  assign mulStart = (state_reg == ST_ISSUE) && !func_reg[2];
  assign divStart = (state_reg == ST_ISSUE) && func_reg[2];
  assign mulA     = mag_a_reg;
  assign mulB     = mag_b_reg;
  assign divA     = mag_a_reg;
  assign divB     = mag_b_reg;

endmodule

// File: tb/tb_ext_dispatch.sv
// Scoreboard bench for ext_dispatch with behavioural multiplier/divider models.
// Define EXT_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_ext_dispatch;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        extStart;
  logic [2:0]  extFunc3;
  logic [31:0] extA;
  logic [31:0] extB;
  logic [31:0] extR;
  logic        extDone;
  logic        extBusy;
  logic        extErr;
  logic        mulStart;
  logic [31:0] mulA;
  logic [31:0] mulB;
  logic [63:0] mulP;
  logic        mulDone;
  logic        divStart;
  logic [31:0] divA;
  logic [31:0] divB;
  logic [31:0] divQ;
  logic [31:0] divRem;
  logic        divDone;

  typedef struct {
    logic [31:0] r;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   unit_delay = 1;
  bit   hang = 0;

  ext_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .extStart(extStart), .extFunc3(extFunc3), .extA(extA), .extB(extB),
    .extR(extR), .extDone(extDone), .extBusy(extBusy), .extErr(extErr),
    .mulStart(mulStart), .mulA(mulA), .mulB(mulB), .mulP(mulP), .mulDone(mulDone),
    .divStart(divStart), .divA(divA), .divB(divB), .divQ(divQ), .divRem(divRem),
    .divDone(divDone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Multiplier: done pulse unit_delay cycles after the start cycle
  initial begin
    logic [31:0] a, b;
    mulDone = 1'b0;
    mulP    = 64'd0;
    forever begin
      @(negedge clk);
      if (mulStart === 1'b1 && !hang) begin
        a = mulA;
        b = mulB;
        repeat (unit_delay) @(negedge clk);
        mulP    = {32'd0, a} * {32'd0, b};
        mulDone = 1'b1;
        @(negedge clk);
        mulDone = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    divDone = 1'b0;
    divQ    = 32'd0;
    divRem  = 32'd0;
    forever begin
      @(negedge clk);
      if (divStart === 1'b1 && !hang) begin
        a = divA;
        b = divB;
        repeat (unit_delay) @(negedge clk);
        divQ    = (b == 0) ? 32'hFFFF_FFFF : a / b;
        divRem  = (b == 0) ? a : a % b;
        divDone = 1'b1;
        @(negedge clk);
        divDone = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference RV32M semantics on two's-complement values
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // d < 0 means the unit never answers (watchdog case)
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int d, input bit extra);
    exp_t e;
    int   n, mul_cnt, div_cnt, late_done;
    bit   got, busy_ok, dbz;
    dbz = f[2] && (b == 0);
    if (d < 0) begin
      e.r = 32'd0; e.err = 1'b1; e.lat = 0;
    end else begin
      e.r = ref_op(f, a, b); e.err = 1'b0; e.lat = dbz ? 2 : d + 3;
    end
    sb.push_back(e);
    hang       = (d < 0);
    unit_delay = (d < 1) ? 1 : d;
    @(negedge clk);
    extStart = 1'b1; extFunc3 = f; extA = a; extB = b;
    @(negedge clk);
    extStart = 1'b0;
    n = 1; mul_cnt = 0; div_cnt = 0; got = 0; busy_ok = 1;
    while (!got && n < 400) begin
      if (mulStart) mul_cnt++;
      if (divStart) div_cnt++;
      if (!extBusy) busy_ok = 0;
      if (extDone) got = 1;
      else begin
        if (extra && n == 2) begin extStart = 1'b1; extFunc3 = 3'd5; extA = 9; extB = 3; end
        if (extra && n == 3) extStart = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check("done_arrived", 64'(got), 64'd1);
      hang = 0;
      return;
    end
    $display("op f=%0d a=%h b=%h -> r=%h err=%0d cycles=%0d", f, a, b, extR, extErr, n);
    check("result", 64'(extR), 64'(e.r));
    check("err", 64'(extErr), 64'(e.err));
    if (e.lat != 0) check("latency", 64'(n), 64'(e.lat));
    check("starts", {32'(mul_cnt), 32'(div_cnt)},
          dbz ? 64'd0 : (f[2] ? {32'd0, 32'd1} : {32'd1, 32'd0}));
    check("busy", 64'(busy_ok), 64'd1);
    @(negedge clk);
    check("done_pulse", 64'(extDone), 64'd0);
    check("hold", 64'(extR), 64'(e.r));
    if (extra) begin
      late_done = 0;
      repeat (8) begin
        @(negedge clk);
        if (extDone) late_done++;
      end
      check("no_extra_done", 64'(late_done), 64'd0);
    end
    hang = 0;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    rst = 1'b1; extStart = 1'b0; extFunc3 = 3'd0; extA = 32'd0; extB = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_r", 64'(extR), 64'd0);
    check("rst_flags", {60'd0, extDone, extBusy, extErr, mulStart}, 64'd0);
    check("rst_div", {62'd0, divStart, 1'b0}, 64'd0);
    check("rst_mulops", {mulA, mulB}, 64'd0);
    check("rst_divops", {divA, divB}, 64'd0);
    rst = 1'b0;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 3, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 2, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 4, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 2, 0);
    do_op(3'd5, 32'd5, 32'd0, 1, 0);
    do_op(3'd7, 32'd5, 32'd0, 1, 0);
    do_op(3'd4, 32'hFFFF_FFFB, 32'd0, 1, 0);
    do_op(3'd6, 32'hFFFF_FFFB, 32'd0, 1, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1);

    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      a = (i % 3 == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      b = (i % 4 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 9)) : $urandom);
      do_op(f, a, b, $urandom_range(1, 6), 0);
    end

    // Reset asserted while waiting on a unit that never answers
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 2, 0);
    hang = 1;
    @(negedge clk);
    extStart = 1'b1; extFunc3 = 3'd0; extA = 32'd3; extB = 32'hFFFF_FFFC;
    @(negedge clk);
    extStart = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_busy", 64'(extBusy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_r", 64'(extR), 64'd0);
    check("abort_flags", {60'd0, extDone, extBusy, extErr, mulStart}, 64'd0);
    check("abort_ops", {mulA, mulB}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hang = 0;
    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 2, 0);

`ifdef EXT_TIMEOUT_EN
    do_op(3'd0, 32'd11, 32'd13, -1, 0);
    do_op(3'd5, 32'd100, 32'd7, 2, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ext_dispatch.md
# ext_dispatch

Sequencer for the CPU's multi-cycle extension port. It accepts one RV32M operation per `extStart` pulse and routes it to a shared unsigned multiplier or an unsigned divider, then applies the sign fix-up and high/low selection. It returns a registered result with a one-cycle `extDone` pulse. It sits between `rv32_CPU_v2` (ext* port) and the mul/div units, replacing the direct CPU-to-`mul` wiring.

## Interface
- `TIMEOUT_CYCLES`, 64: WAIT-state watchdog limit (used only with `EXT_TIMEOUT_EN`).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `extStart`  in  1  one-cycle request pulse from CPU.
- `extFunc3`  in  3  RV32M funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
- `extA`, `extB`  in  32  operands rs1, rs2.
- `extR`  out  32  result; valid in the `extDone` cycle and held until the next accepted start.
- `extDone`  out  1  one-cycle completion pulse.
- `extBusy`  out  1  high from the cycle after acceptance through the `extDone` cycle.
- `extErr`  out  1  timeout flag, valid with `extDone`.
- `mulStart`  out  1  one-cycle start to the multiplier.
- `mulA`, `mulB`  out  32  multiplier operand magnitudes.
- `mulP`  in  64  unsigned product.
- `mulDone`  in  1  multiplier completion.
- `divStart`  out  1  one-cycle start to the divider.
- `divA`, `divB`  out  32  divider operand magnitudes.
- `divQ`, `divRem`  in  32  unsigned quotient and remainder.
- `divDone`  in  1  divider completion.

## Operation
- States: IDLE, ISSUE, WAIT, FIX, RESP.
- IDLE:
  - `extStart` latches func3, A and B, computes operand magnitudes and the result sign, then moves to ISSUE.
  - Exception: DIV/DIVU/REM/REMU with B==0 takes a fast path to FIX without engaging the divider.
- Operand signedness:
  - A is signed for MUL, MULH, MULHSU, DIV and REM.
  - B is signed for MUL, MULH, DIV and REM.
  - A magnitude = A[31] ? -A : A when A is signed; B likewise.
- Unit select is `extFunc3[2]`: 0 selects the multiplier, 1 the divider. The unselected unit's start stays low.
- ISSUE: assert the selected unit's start for exactly one cycle, drive the magnitudes, go to WAIT. A unit done seen in ISSUE is ignored.
- WAIT: hold the magnitudes stable. The selected unit's done moves to FIX. The other unit's done is ignored.
- FIX: register `extR`.
  - Multiplier result: negate the 64-bit product when sign(A) XOR sign(B), using signed flags only. MUL takes the low 32 bits; MULH, MULHSU and MULHU take the high 32 bits.
  - Quotient: negate when signA XOR signB.
  - Remainder: negate when signA.
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = A unmodified.
  - Overflow 0x80000000 / -1 needs no special case: magnitude arithmetic yields quotient 0x80000000 and remainder 0.
- RESP: pulse `extDone`, return to IDLE.
- `extStart` outside IDLE is ignored, with no queuing.
- Stray unit done pulses in IDLE, FIX or RESP are ignored.

## Timing
- Reset values: all outputs are 0 (`extR`, `extDone`, `extBusy`, `extErr`, both starts, all operand outputs); the state is IDLE.
- Reset asserted mid-operation aborts immediately and asynchronously, and unit starts drop the same instant. Units are reset by the same `rst`.
- Cycle numbering from the `extStart` cycle as 0:
  - Normal path: unit start in cycle 1. If the unit done arrives in cycle k (k ≥ 2), `extDone` is in cycle k+2.
  - Divide-by-zero: `extDone` in cycle 2.
- A new `extStart` is accepted in the cycle after `extDone`, when the state is IDLE.

## Configuration
- `EXT_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching `TIMEOUT_CYCLES` without the selected done, go to RESP with `extR`=0 and `extErr`=1 for the `extDone` cycle.
  - `extErr` clears on the next accepted start.
- Undefined: no counter; `extErr` is tied to 0 and WAIT waits indefinitely.

## Structure
- Shared package `ext_pkg`: funct3 localparams (F3_MUL … F3_REMU), the state typedef, and the divide-by-zero quotient constant 32'hFFFFFFFF.
- One natural sub-module: `ext_signfix`, combinational. It produces magnitudes and sign flags from func3, A and B, and a negate/select helper for the result.

## Test plan
- MUL A=7, B=0xFFFFFFFD (-3), mul done 3 cycles after `mulStart` → `extR`=0xFFFFFFEB. `extDone` arrives 6 cycles after `extStart` (done in cycle 4, per k+2); `divStart` never rises.
- MULHU A=B=0xFFFFFFFF → `extR`=0xFFFFFFFE. MULH with the same operands → `extR`=0x00000000.
- DIV A=0xFFFFFFF9 (-7), B=2 → `extR`=0xFFFFFFFD. REM with the same operands → `extR`=0xFFFFFFFF.
- DIVU A=5, B=0 → `extR`=0xFFFFFFFF, `extDone` in cycle 2, no `divStart`. REMU A=5, B=0 → `extR`=5.
- DIV A=0x80000000, B=0xFFFFFFFF → `extR`=0x80000000. REM with the same operands → 0. A second `extStart` issued while busy produces no additional `extDone`.
- With `EXT_TIMEOUT_EN` and a mul done that never comes → `extDone` with `extErr`=1 and `extR`=0 after `TIMEOUT_CYCLES`.
- `rst` asserted during WAIT → all outputs 0 at once; the next operation completes normally.
